cla_seq_adder: RTL and testbench

//  Sequential carry-lookahead adder built around the kill/propagate/generate (KPG) prefix

---
 rtl/cla_pkg.sv | 28 ++
 rtl/cla_prefix_step.sv | 27 ++
 rtl/cla_seq_adder.sv | 85 ++++++++
 tb/tb_cla_seq_adder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// KPG symbol type, controller states and the encode/combine helpers
// shared by the sequential carry-lookahead adder.
package cla_pkg;

  typedef enum logic [1:0] {
    KPG_K = 2'b00,
    KPG_P = 2'b01,
    KPG_G = 2'b10
  } kpg_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREFIX,
    S_DONE
  } state_t;

  function automatic kpg_t kpg_enc(input logic a_bit, input logic b_bit);
    if (a_bit & b_bit) return KPG_G;
    else if (a_bit ^ b_bit) return KPG_P;
    else return KPG_K;
  endfunction

  // A propagating position takes the status of the span below it.
  function automatic kpg_t kpg_comb(input kpg_t hi, input kpg_t lo);
    return (hi == KPG_P) ? lo : hi;
  endfunction

endpackage

// File: rtl/cla_prefix_step.sv
// One KPG prefix level: every position i >= 2^lvl combines with position
// i-2^lvl, using only the incoming (pre-level) vector.
module cla_prefix_step
  import cla_pkg::*;
#(
  parameter int W      = 64,
  parameter int LEVELS = $clog2(W + 1),
  parameter int LVL_W  = $clog2(LEVELS)
) (
  input  kpg_t [W:0]       vec,
  input  logic [LVL_W-1:0] lvl,
  output kpg_t [W:0]       nxt
);

  for (genvar i = 0; i <= W; i++) begin : g_bit
    kpg_t [LEVELS-1:0] cand;
    for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
      if (i >= (1 << j)) begin : g_comb
        assign cand[j] = kpg_comb(vec[i], vec[i-(1<<j)]);
      end else begin : g_pass
        assign cand[j] = vec[i];
      end
    end
    assign nxt[i] = cand[lvl];
  end

endmodule

// File: rtl/cla_seq_adder.sv
// Sequential CLA: encode operands to KPG, resolve one prefix level per clock,
// decode carries into sum/cout; valid/ready on both sides.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int LEVELS = $clog2(W + 1);
  localparam int LVL_W  = $clog2(LEVELS);

  state_t           state, state_nxt;
  logic [LVL_W-1:0] lvl;
  kpg_t [W:0]       vec, vec_enc, vec_nxt;
  logic [W-1:0]     hp, sum_dec;
  logic             accept, last;

  // Position 0 carries cin; position i+1 describes operand bit i.
  assign vec_enc[0] = cin ? KPG_G : KPG_K;
  for (genvar i = 0; i < W; i++) begin : g_enc
    assign vec_enc[i+1] = kpg_enc(a[i], b[i]);
    assign sum_dec[i]   = hp[i] ^ (vec_nxt[i] == KPG_G);
  end

  cla_prefix_step #(.W(W), .LEVELS(LEVELS), .LVL_W(LVL_W)) u_step (
    .vec (vec),
    .lvl (lvl),
    .nxt (vec_nxt)
  );

  assign last      = (lvl == LVL_W'(LEVELS - 1));
  assign in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (in_valid) state_nxt = S_PREFIX;
      S_PREFIX: if (last) state_nxt = S_DONE;
      S_DONE:   if (out_ready) state_nxt = in_valid ? S_PREFIX : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl  <= '0;
      hp   <= '0;
      sum  <= '0;
      cout <= 1'b0;
      for (int i = 0; i <= W; i++) vec[i] <= KPG_K;
    end else if (accept) begin
      // sum/cout are left alone here so a retiring result stays intact.
      vec <= vec_enc;
      hp  <= a ^ b;
      lvl <= '0;
    end else if (state == S_PREFIX) begin
      vec <= vec_nxt;
      lvl <= lvl + LVL_W'(1);
      if (last) begin
        sum  <= sum_dec;
        cout <= (vec_nxt[W] == KPG_G);
      end
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder: directed W=64 vectors, random ops with
// random backpressure, and a W=8 sweep checking latency and sum.
module tb_cla_seq_adder;
  import cla_pkg::*;

  localparam int W      = 64;
  localparam int LEVELS = 7;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, cout, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0, sum;

  logic         iv8 = 1'b0, ir8, ov8, or8 = 1'b1, c8, cin8 = 1'b0;
  logic [7:0]   a8 = '0, b8 = '0, s8;

  int   n_tests = 0, n_fail = 0, cyc = 0, acc_cyc = 0;
  bit   rnd = 1'b0;
  logic ov_q = 1'b0;
  res_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cla_seq_adder #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  cla_seq_adder #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(ov8), .out_ready(or8),
    .sum(s8), .cout(c8)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: latency and no-P on each rising out_valid, scoreboard pop on retire.
  always @(negedge clk) begin : mon
    res_t r;
    logic nop;
    if (rst_n) begin
      if (out_valid && !ov_q) begin
        check("latency", 128'(cyc - acc_cyc), 128'(LEVELS));
        nop = 1'b1;
        for (int i = 0; i <= W; i++) if (dut.vec[i] == KPG_P) nop = 1'b0;
        check("no_p_at_done", 128'(nop), 128'(1));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 128'(1), 128'(0));
        else begin
          r = exp_q.pop_front();
          check("sum", 128'(sum), 128'(r.sum));
          check("cout", 128'(cout), 128'(r.cout));
        end
      end
    end
    ov_q <= out_valid;
  end

  initial begin : rnd_ready
    forever begin
      @(posedge clk);
      #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Entered and left at posedge+1; leaves in_valid low after the accept edge.
  task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc,
                      input logic [W-1:0] es, input logic ec);
    bit ok = 1'b0;
    a = aa; b = bb; cin = cc; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check("send_timeout", 128'(0), 128'(1));
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back('{sum: es, cout: ec});
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) check("drain_timeout", 128'(0), 128'(1));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [W:0] ref_sum;
    logic [8:0] ref8;
    bit seen;
    int lat;

    // reset state
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_sum", 128'(sum), 128'(0));
    check("rst_cout", 128'(cout), 128'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;

    // all-ones + 1 wraps to zero with carry out
    send('1, 64'd1, 1'b0, 64'd0, 1'b1);
    drain();

    // cin alone, then MSB+MSB
    send(64'd0, 64'd0, 1'b1, 64'd1, 1'b0);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1);
    drain();

    // backpressure, then retire and accept on the same edge
    out_ready = 1'b0;
    send(64'd10, 64'd20, 1'b0, 64'd30, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    check("bp_result_seen", 128'(seen), 128'(1));
    repeat (5) begin
      @(negedge clk);
      check("bp_sum_stable", 128'(sum), 128'(30));
      check("bp_in_ready", 128'(in_ready), 128'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(64'd3, 64'd4, 1'b0, 64'd7, 1'b0);
    drain();

    // reset mid-PREFIX discards the operation
    send(64'd5, 64'd6, 1'b0, 64'd11, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_sum_cleared", 128'(sum), 128'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen = 1'b1;
    end
    check("midrst_no_stale", 128'(seen), 128'(0));
    @(posedge clk); #1;
    send(64'd1, 64'd1, 1'b0, 64'd2, 1'b0);
    drain();

    // in_valid wiggling during PREFIX is ignored
    send(64'd100, 64'd200, 1'b1, 64'd301, 1'b0);
    a = '1; b = '1; in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("prefix_in_ready", 128'(in_ready), 128'(0));
      @(posedge clk); #1 in_valid = ~in_valid;
    end
    in_valid = 1'b0;
    drain();

    // random operands with random out_ready
    rnd = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra, rb;
      logic rc;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      ref_sum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      send(ra, rb, rc, ref_sum[W-1:0], ref_sum[W]);
    end
    rnd = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    // W=8 (4 levels) sweep
    for (int ia = 0; ia < 256; ia += 15) begin
      for (int ib = 0; ib < 256; ib += 51) begin
        for (int ic = 0; ic < 2; ic++) begin
          a8 = 8'(ia); b8 = 8'(ib); cin8 = 1'(ic); iv8 = 1'b1;
          ref8 = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
          @(posedge clk); #1 iv8 = 1'b0;
          lat = 0;
          while (!ov8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
          end
          check("w8_latency", 128'(lat), 128'(4));
          check("w8_sum", 128'({c8, s8}), 128'(ref8));
          @(posedge clk); #1;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
